seqmul_cmp42_ctrl: RTL
======================

Name: seqmul_cmp42_ctrl

Overview:
- Sequential controller for an unsigned WIDTHxWIDTH multiplier.
- One shared row of 4:2 compressor cells is reused across multiple cycles. Each cell is built from two full adders, with inputs x1..x4 and cin, and outputs c0, s and c.
- The row reduces two partial-product rows per cycle into a carry-save accumulator. A final cycle resolves the accumulator into the product.
- Sits between the operand source and the product consumer, with valid/ready handshakes on both sides.

Parameters:
- WIDTH, 8, operand width; must be even and >= 4. Number of accumulate steps NSTEP = WIDTH/2.
- APPROX_COLS, 0, number of low product columns that use the approximate cell. Has an effect only when the optional macro is defined; legal range 0..2*WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operands valid
- in_ready  output  1  controller can accept operands
- a  input  WIDTH  multiplicand
- b  input  WIDTH  multiplier
- out_valid  output  1  product valid
- out_ready  input  1  consumer accepts product
- product  output  2*WIDTH  a*b
- busy  output  1  high in ACCUM or RESOLVE

Behaviour:
- Interface (already decided): one clock, clk. Reset rst is synchronous and active-high.
- Reset: on an rst edge, state=IDLE, step=0, S=0, C=0, product=0, out_valid=0, busy=0. After reset, in_ready=1.
- Reset dominates every other event, including mid-ACCUM and mid-DONE. Any in-flight operation is discarded and no output is produced.
- States: IDLE, ACCUM, RESOLVE, DONE.
  - in_ready = (state==IDLE).
  - busy = (state==ACCUM or RESOLVE).
- IDLE:
  - On in_valid & in_ready: register a and b, clear S and C, set step=0, go to ACCUM.
  - No other input has effect.
- ACCUM, step i:
  - pp0 = (b[2i] ? a : 0) << 2i
  - pp1 = (b[2i+1] ? a : 0) << (2i+1)
  - Both are zero-extended to 2*WIDTH bits.
  - Column j of the row takes x1=S[j], x2=C[j], x3=pp0[j], x4=pp1[j], cin = c0 of column j-1 (column 0 has cin=0).
  - Next-state update: S[j] <= s_j; C[j+1] <= c_j; C[0] <= 0. The top column's c and c0 are dropped; no overflow is possible.
  - step increments each cycle. After step NSTEP-1, go to RESOLVE.
- RESOLVE:
  - product <= S + C, taken modulo 2^(2*WIDTH).
  - out_valid <= 1; go to DONE.
- DONE:
  - product and out_valid are held stable until out_ready.
  - On out_valid & out_ready: out_valid <= 0, go to IDLE.
  - in_valid is ignored while not in IDLE, so there is no back-to-back acceptance.
- Latency: if the accept edge is cycle 0, out_valid rises after the edge of cycle NSTEP+1. For WIDTH=8 that is 5 cycles, and the next accept is possible no earlier than 1 cycle after the out handshake.
- in_valid may drop during the operation without effect. The a and b ports are don't-care after acceptance.

Optional Feature:
- Macro: SEQMUL_APPROX_EN.
- Defined: columns j < APPROX_COLS use the approximate cell, with s = x1|x2|x3|x4|cin, c = 0, c0 = 0. Columns >= APPROX_COLS use the exact cell.
- Undefined: every column is exact, APPROX_COLS is ignored, and product == a*b for all inputs.
- With the macro defined and APPROX_COLS=0, results must be bit-identical to the undefined build.

Decomposition:
- Shared package seqmul_pkg holds:
  - the state enum (IDLE, ACCUM, RESOLVE, DONE);
  - a function computing NSTEP from WIDTH;
  - the step-counter width, $clog2(NSTEP).
- Natural sub-module cmp42_row: a purely combinational row of 2*WIDTH compressor cells with the c0->cin chain, plus the per-column approx select under SEQMUL_APPROX_EN. The controller instantiates exactly one cmp42_row.

Test Plan:
- Reset then a=3, b=3, in_valid for 1 cycle, out_ready=1: out_valid rises 5 cycles after accept, product=9 (0x0009), in_ready returns to 1 the cycle after the handshake.
- a=0xFF, b=0xFF -> product=0xFE01. Then a=0x00, b=0xA5 -> product=0x0000. Then a=0x80, b=0x02 -> product=0x0100.
- Backpressure: a=0x12, b=0x34 with out_ready=0 for 10 cycles -> product=0x03A8 held stable and out_valid held at 1. Then out_ready=1 -> one-cycle handshake, then IDLE.
- in_valid held high with new a and b during ACCUM and DONE -> ignored. Only the first operands (a=7, b=9) are processed, product=63.
- rst asserted on the 3rd ACCUM cycle -> the next cycle shows out_valid=0, busy=0, in_ready=1, product=0, and no stale product appears later.
- With SEQMUL_APPROX_EN, APPROX_COLS=4, a=3, b=3 -> product=7. With APPROX_COLS=0 -> 9. Random 1000-vector sweep with the macro undefined -> product == a*b.

Source files
------------

// File: rtl/seqmul_pkg.sv
// Shared types and helpers for the sequential 4:2-compressor multiplier.
// Holds the controller state encoding and the step-count arithmetic derived from WIDTH.
package seqmul_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        DONE    = 2'd3
    } state_t;

    // Two multiplier bits are consumed per accumulate step.
    function automatic int nstep(input int width);
        return width / 2;
    endfunction

    function automatic int step_w(input int width);
        return (width / 2 > 1) ? $clog2(width / 2) : 1;
    endfunction

endpackage

// File: rtl/cmp42_row.sv
// Purpose: one combinational row of 4:2 compressors, two full adders per column.
// Latency: 0 cycles (pure combinational). Backpressure: none.
// Low columns switch to an OR-based approximate cell when SEQMUL_APPROX_EN is defined.
module cmp42_row #(
    parameter int W2          = 16,
    parameter int APPROX_COLS = 0
) (
    input  logic [W2-1:0] s_in,
    input  logic [W2-1:0] c_in,
    input  logic [W2-1:0] pp0,
    input  logic [W2-1:0] pp1,
    output logic [W2-1:0] s_out,
    output logic [W2-1:0] c_out
);

    // chain[j] is the cin of column j, fed by c0 of column j-1.
    logic [W2-1:0] chain;

    assign chain[0] = 1'b0;
    assign c_out[0] = 1'b0;

    for (genvar j = 0; j < W2; j++) begin : g_col
`ifdef SEQMUL_APPROX_EN
        localparam bit AX = (j < APPROX_COLS);
`else
        localparam bit AX = 1'b0 && (j < APPROX_COLS);
`endif
        logic x1, x2, x3, x4, cin;
        assign x1  = s_in[j];
        assign x2  = c_in[j];
        assign x3  = pp0[j];
        assign x4  = pp1[j];
        assign cin = chain[j];

        if (AX) begin : g_approx
            assign s_out[j] = x1 | x2 | x3 | x4 | cin;
            if (j < W2 - 1) begin : g_carry
                assign chain[j+1] = 1'b0;
                assign c_out[j+1] = 1'b0;
            end
        end else begin : g_exact
            assign s_out[j] = x1 ^ x2 ^ x3 ^ x4 ^ cin;
            // Top column's c and c0 would leave the product width, so they are never built.
            if (j < W2 - 1) begin : g_carry
                logic s1;
                assign s1         = x1 ^ x2 ^ x3;
                assign chain[j+1] = (x1 & x2) | (x1 & x3) | (x2 & x3);
                assign c_out[j+1] = (s1 & x4) | (s1 & cin) | (x4 & cin);
            end
        end
    end

endmodule

// File: rtl/seqmul_cmp42_ctrl.sv
// Purpose: unsigned WIDTHxWIDTH sequential multiplier, two partial products per cycle via one cmp42_row.
// Latency: out_valid rises WIDTH/2+1 cycles after the accept edge. Backpressure: holds product until out_ready.
// Optional approximate low columns under SEQMUL_APPROX_EN (APPROX_COLS sets how many).
module seqmul_cmp42_ctrl
    import seqmul_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int APPROX_COLS = 0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [2*WIDTH-1:0] product,
    output logic               busy
);

    localparam int NSTEP  = nstep(WIDTH);
    localparam int STEP_W = step_w(WIDTH);
    localparam int W2     = 2 * WIDTH;
    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEP - 1);

    state_t            state;
    logic [STEP_W-1:0] step;
    logic [W2-1:0]     acc_s;
    logic [W2-1:0]     acc_c;
    logic [W2-1:0]     a_sh;
    logic [WIDTH-1:0]  b_sh;
    logic [W2-1:0]     pp0;
    logic [W2-1:0]     pp1;
    logic [W2-1:0]     row_s;
    logic [W2-1:0]     row_c;

    // a_sh already carries the 2i shift; b_sh[1:0] are multiplier bits 2i and 2i+1.
    assign pp0 = b_sh[0] ? a_sh : '0;
    assign pp1 = b_sh[1] ? {a_sh[W2-2:0], 1'b0} : '0;

    cmp42_row #(
        .W2          (W2),
        .APPROX_COLS (APPROX_COLS)
    ) u_row (
        .s_in  (acc_s),
        .c_in  (acc_c),
        .pp0   (pp0),
        .pp1   (pp1),
        .s_out (row_s),
        .c_out (row_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            step      <= '0;
            acc_s     <= '0;
            acc_c     <= '0;
            a_sh      <= '0;
            b_sh      <= '0;
            product   <= '0;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        a_sh     <= {{WIDTH{1'b0}}, a};
                        b_sh     <= b;
                        acc_s    <= '0;
                        acc_c    <= '0;
                        step     <= '0;
                        state    <= ACCUM;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ACCUM: begin
                    acc_s <= row_s;
                    acc_c <= row_c;
                    a_sh  <= {a_sh[W2-3:0], 2'b00};
                    b_sh  <= {2'b00, b_sh[WIDTH-1:2]};
                    step  <= step + 1'b1;
                    if (step == LAST_STEP) begin
                        state <= RESOLVE;
                    end
                end
                RESOLVE: begin
                    product   <= acc_s + acc_c;
                    out_valid <= 1'b1;
                    busy      <= 1'b0;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                    in_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule
